// File: rtl/riscv_lsu_split.sv
// riscv_lsu_split: registered LSU FSM. It splits misaligned accesses into two aligned beats and has a bus timeout.
// Define LSU_MISALIGN_SPLIT_EN to enable two-beat splitting; otherwise split accesses fault as misaligned.
module riscv_lsu_split #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              core_req_i,
  input  logic              core_we_i,
  input  logic [2:0]        core_size_i,
  input  logic [ADDR_W-1:0] core_addr_i,
  input  logic [31:0]       core_wd_i,
  output logic [31:0]       core_rd_o,
  output logic              core_stall_o,
  output logic              core_fault_o,
  output logic [1:0]        core_fault_cause_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_be_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wd_o,
  input  logic [31:0]       mem_rd_i,
  input  logic              mem_ready_i
);
`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif
  localparam int CW = $clog2(TIMEOUT + 2);
  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, DONE} state_t;
  state_t state, nxt;
  logic [ADDR_W-1:0] addr_q, a, b0_addr, maddr_n;
  logic [2:0] size_q, sz;
  logic we_q, we, split, tmo, req_n, we_n, fault_n;
  logic [31:0] wd_q, wd, rd0, rd1, rd0_n, rd1_n, sh, ext, mwd_n, rd_n;
  logic [1:0] off, cause_n;
  logic [3:0] base, be_n;
  logic [7:0] be8;
  logic [63:0] sd64;
  logic [CW-1:0] cnt, cnt_n;
  // In IDLE the beat-0 registers are loaded straight from the core inputs
  assign a       = state == IDLE ? core_addr_i : addr_q;
  assign sz      = state == IDLE ? core_size_i : size_q;
  assign we      = state == IDLE ? core_we_i : we_q;
  assign wd      = state == IDLE ? core_wd_i : wd_q;
  assign off     = a[1:0];
  assign base    = sz[1:0] == 2'b00 ? 4'b0001 : sz[1:0] == 2'b01 ? 4'b0011 : 4'b1111;
  assign be8     = {4'b0, base} << off;
  assign sd64    = {32'b0, wd} << {off, 3'b000};
  assign split   = |be8[7:4];
  assign b0_addr = {a[ADDR_W-1:2], 2'b00};
  assign tmo     = TIMEOUT != 0 && cnt == CW'(TIMEOUT - 1);
  assign rd0_n   = state == BEAT0 && mem_ready_i ? mem_rd_i : rd0;
  assign rd1_n   = state == BEAT1 && mem_ready_i ? mem_rd_i : rd1;
  assign sh      = 32'({rd1_n, rd0_n} >> {off, 3'b000});
  assign ext     = sz[1:0] == 2'b00 ? {{24{~sz[2] & sh[7]}}, sh[7:0]}
                 : sz[1:0] == 2'b01 ? {{16{~sz[2] & sh[15]}}, sh[15:0]} : sh;
  assign core_stall_o = state == IDLE ? core_req_i : state != DONE;
  always_comb begin
    nxt = state;
    req_n = 1'b0;
    we_n = 1'b0;
    be_n = 4'b0;
    maddr_n = '0;
    mwd_n = 32'b0;
    rd_n = 32'b0;
    fault_n = 1'b0;
    cause_n = 2'b00;
    cnt_n = '0;
    case (state)
      IDLE: if (core_req_i) begin
        if (!SPLIT_EN && split) begin
          nxt = DONE;
          fault_n = 1'b1;
          cause_n = 2'b01;
        end else begin
          nxt = BEAT0;
          req_n = 1'b1;
          we_n = we;
          be_n = be8[3:0];
          maddr_n = b0_addr;
          mwd_n = sd64[31:0];
        end
      end
      BEAT0, BEAT1: if (mem_ready_i) begin
        if (state == BEAT0 && SPLIT_EN && split) begin
          nxt = BEAT1;
          req_n = 1'b1;
          we_n = we_q;
          be_n = be8[7:4];
          maddr_n = b0_addr + ADDR_W'(4);
          mwd_n = sd64[63:32];
        end else begin
          nxt = DONE;
          rd_n = we_q ? 32'b0 : ext;
        end
      end else if (tmo) begin
        nxt = DONE;
        fault_n = 1'b1;
        cause_n = 2'b10;
      end else begin
        req_n = 1'b1;
        we_n = mem_we_o;
        be_n = mem_be_o;
        maddr_n = mem_addr_o;
        mwd_n = mem_wd_o;
        cnt_n = cnt + CW'(1);
      end
      DONE: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      addr_q <= '0;
      size_q <= 3'b0;
      we_q <= 1'b0;
      wd_q <= 32'b0;
      rd0 <= 32'b0;
      rd1 <= 32'b0;
      cnt <= '0;
      mem_req_o <= 1'b0;
      mem_we_o <= 1'b0;
      mem_be_o <= 4'b0;
      mem_addr_o <= '0;
      mem_wd_o <= 32'b0;
      core_rd_o <= 32'b0;
      core_fault_o <= 1'b0;
      core_fault_cause_o <= 2'b00;
    end else begin
      state <= nxt;
      if (state == IDLE && core_req_i) begin
        addr_q <= core_addr_i;
        size_q <= core_size_i;
        we_q <= core_we_i;
        wd_q <= core_wd_i;
      end
      rd0 <= rd0_n;
      rd1 <= rd1_n;
      cnt <= cnt_n;
      mem_req_o <= req_n;
      mem_we_o <= we_n;
      mem_be_o <= be_n;
      mem_addr_o <= maddr_n;
      mem_wd_o <= mwd_n;
      core_rd_o <= rd_n;
      core_fault_o <= fault_n;
      core_fault_cause_o <= cause_n;
    end
  end
endmodule

// File: tb/tb_riscv_lsu_split.sv
// tb_riscv_lsu_split: scoreboard bench; expected beats and results are queued at drive time and popped as the DUT responds.
module tb_riscv_lsu_split;
  logic clk_i = 1'b0, rst_i = 1'b1;
  logic core_req_i = 1'b0, core_we_i = 1'b0;
  logic [2:0] core_size_i = 3'b0;
  logic [31:0] core_addr_i = 32'b0, core_wd_i = 32'b0;
  logic [31:0] core_rd_o;
  logic core_stall_o, core_fault_o;
  logic [1:0] core_fault_cause_o;
  logic mem_req_o, mem_we_o;
  logic [3:0] mem_be_o;
  logic [31:0] mem_addr_o, mem_wd_o;
  logic [31:0] mem_rd_i = 32'b0;
  logic mem_ready_i = 1'b0;
  int tests = 0, fails = 0;
  typedef struct {logic [31:0] addr; logic [3:0] be; logic [31:0] wd; logic we;} beat_t;
  typedef struct {logic [31:0] rd; logic fault; logic [1:0] cause; int stalls; int reqs;} res_t;
  beat_t bq[$];
  res_t rq[$];
  always #5 clk_i = ~clk_i;
  riscv_lsu_split #(.ADDR_W(32), .TIMEOUT(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .core_req_i(core_req_i), .core_we_i(core_we_i),
    .core_size_i(core_size_i), .core_addr_i(core_addr_i), .core_wd_i(core_wd_i),
    .core_rd_o(core_rd_o), .core_stall_o(core_stall_o), .core_fault_o(core_fault_o),
    .core_fault_cause_o(core_fault_cause_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o), .mem_wd_o(mem_wd_o),
    .mem_rd_i(mem_rd_i), .mem_ready_i(mem_ready_i)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // w0/w1: wait cycles before ready on each beat (large = never ready)
  task automatic access(input string tag, input logic we, input logic [2:0] sz, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rd0, input logic [31:0] rd1,
                        input int w0, input int w1, input int nb, input beat_t e0, input beat_t e1, input res_t er);
    int beat, wcnt, stalls, reqs;
    bit done;
    logic [31:0] rdv [2];
    int wv [2];
    beat_t b;
    res_t r;
    beat = 0; wcnt = 0; stalls = 0; reqs = 0; done = 0;
    rdv[0] = rd0; rdv[1] = rd1; wv[0] = w0; wv[1] = w1;
    if (nb > 0) bq.push_back(e0);
    if (nb > 1) bq.push_back(e1);
    rq.push_back(er);
    core_req_i = 1'b1; core_we_i = we; core_size_i = sz; core_addr_i = addr; core_wd_i = wd;
    for (int i = 0; i < 40 && !done; i++) begin
      #1;
      if (!core_stall_o) begin
        r = rq.pop_front();
        check({tag, " rd"}, core_rd_o, r.rd);
        check({tag, " fault"}, 32'(core_fault_o), 32'(r.fault));
        check({tag, " cause"}, 32'(core_fault_cause_o), 32'(r.cause));
        check({tag, " stall cycles"}, stalls, r.stalls);
        check({tag, " req cycles"}, reqs, r.reqs);
        check({tag, " be idle"}, 32'(mem_be_o), 32'h0);
        done = 1;
        core_req_i = 1'b0;
        mem_ready_i = 1'b0;
      end else begin
        stalls++;
        mem_ready_i = 1'b0;
        if (mem_req_o) begin
          reqs++;
          if (beat < 2 && wcnt == wv[beat]) begin
            if (bq.size() == 0) check({tag, " unexpected beat"}, 32'(beat), 32'(nb));
            else begin
              b = bq.pop_front();
              check({tag, " beat addr"}, mem_addr_o, b.addr);
              check({tag, " beat be"}, 32'(mem_be_o), 32'(b.be));
              check({tag, " beat wd"}, mem_wd_o, b.wd);
              check({tag, " beat we"}, 32'(mem_we_o), 32'(b.we));
            end
            mem_ready_i = 1'b1;
            mem_rd_i = rdv[beat];
            beat++;
            wcnt = 0;
          end else wcnt++;
        end
      end
      @(negedge clk_i);
    end
    if (!done) begin
      check({tag, " retire"}, 32'd0, 32'd1);
      core_req_i = 1'b0;
      mem_ready_i = 1'b0;
      void'(rq.pop_front());
    end
    check({tag, " beats left"}, 32'(bq.size()), 32'd0);
    bq.delete();
    @(negedge clk_i);
  endtask
  localparam beat_t NB = '{32'h0, 4'h0, 32'h0, 1'b0};
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    #2;
    check("reset mem_req", 32'(mem_req_o), 32'h0);
    check("reset stall", 32'(core_stall_o), 32'h0);
    check("reset rd", core_rd_o, 32'h0);
    check("reset fault", 32'(core_fault_o), 32'h0);
    core_req_i = 1'b1;
    #1;
    check("reset stall follows req", 32'(core_stall_o), 32'h1);
    core_req_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    access("lw", 0, 3'd2, 32'h100, 0, 32'h8899AABB, 0, 0, 0, 1,
           beat_t'{32'h100, 4'hF, 32'h0, 1'b0}, NB, res_t'{32'h8899AABB, 1'b0, 2'b00, 2, 1});
    access("lb", 0, 3'd0, 32'h103, 0, 32'h80112233, 0, 0, 0, 1,
           beat_t'{32'h100, 4'h8, 32'h0, 1'b0}, NB, res_t'{32'hFFFFFF80, 1'b0, 2'b00, 2, 1});
    access("lbu", 0, 3'd4, 32'h103, 0, 32'h80112233, 0, 0, 0, 1,
           beat_t'{32'h100, 4'h8, 32'h0, 1'b0}, NB, res_t'{32'h00000080, 1'b0, 2'b00, 2, 1});
    access("sb", 1, 3'd0, 32'h102, 32'h1234565A, 0, 0, 1, 0, 1,
           beat_t'{32'h100, 4'h4, 32'h565A0000, 1'b1}, NB, res_t'{32'h0, 1'b0, 2'b00, 3, 2});
    access("size3 lw", 0, 3'd3, 32'h108, 0, 32'hCAFEF00D, 0, 0, 0, 1,
           beat_t'{32'h108, 4'hF, 32'h0, 1'b0}, NB, res_t'{32'hCAFEF00D, 1'b0, 2'b00, 2, 1});
    access("timeout", 0, 3'd2, 32'h300, 0, 0, 0, 99, 0, 0,
           NB, NB, res_t'{32'h0, 1'b1, 2'b10, 5, 4});
    access("ready at limit", 0, 3'd2, 32'h304, 0, 32'h12345678, 0, 3, 0, 1,
           beat_t'{32'h304, 4'hF, 32'h0, 1'b0}, NB, res_t'{32'h12345678, 1'b0, 2'b00, 5, 4});
`ifdef LSU_MISALIGN_SPLIT_EN
    access("sw split", 1, 3'd2, 32'h201, 32'hDEADBEEF, 0, 0, 0, 0, 2,
           beat_t'{32'h200, 4'hE, 32'hADBEEF00, 1'b1}, beat_t'{32'h204, 4'h1, 32'h000000DE, 1'b1},
           res_t'{32'h0, 1'b0, 2'b00, 3, 2});
    access("lh split", 0, 3'd1, 32'h103, 0, 32'h34AABBCC, 32'hDDEEFF12, 0, 0, 2,
           beat_t'{32'h100, 4'h8, 32'h0, 1'b0}, beat_t'{32'h104, 4'h1, 32'h0, 1'b0},
           res_t'{32'h00001234, 1'b0, 2'b00, 3, 2});
    access("lhu split", 0, 3'd5, 32'h103, 0, 32'h34AABBCC, 32'hDDEEFF80, 0, 0, 2,
           beat_t'{32'h100, 4'h8, 32'h0, 1'b0}, beat_t'{32'h104, 4'h1, 32'h0, 1'b0},
           res_t'{32'h00008034, 1'b0, 2'b00, 3, 2});
    access("lh split neg", 0, 3'd1, 32'h103, 0, 32'h34AABBCC, 32'hDDEEFF80, 0, 0, 2,
           beat_t'{32'h100, 4'h8, 32'h0, 1'b0}, beat_t'{32'h104, 4'h1, 32'h0, 1'b0},
           res_t'{32'hFFFF8034, 1'b0, 2'b00, 3, 2});
    access("lw split wait", 0, 3'd2, 32'h002, 0, 32'hBBAA1111, 32'h2222DDCC, 1, 2, 2,
           beat_t'{32'h000, 4'hC, 32'h0, 1'b0}, beat_t'{32'h004, 4'h3, 32'h0, 1'b0},
           res_t'{32'hDDCCBBAA, 1'b0, 2'b00, 6, 5});
`else
    access("sw misalign", 1, 3'd2, 32'h201, 32'hDEADBEEF, 0, 0, 0, 0, 0,
           NB, NB, res_t'{32'h0, 1'b1, 2'b01, 1, 0});
    access("lh misalign", 0, 3'd1, 32'h103, 0, 0, 0, 0, 0, 0,
           NB, NB, res_t'{32'h0, 1'b1, 2'b01, 1, 0});
    access("lw misalign", 0, 3'd2, 32'h002, 0, 0, 0, 0, 0, 0,
           NB, NB, res_t'{32'h0, 1'b1, 2'b01, 1, 0});
`endif
    core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = 3'd2; core_addr_i = 32'h100;
    @(negedge clk_i);
    #1;
    check("beat0 req before reset", 32'(mem_req_o), 32'h1);
    rst_i = 1'b1;
    #1;
    check("async reset drops req", 32'(mem_req_o), 32'h0);
    check("async reset be", 32'(mem_be_o), 32'h0);
    core_req_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    access("lw after reset", 0, 3'd2, 32'h100, 0, 32'h0BADF00D, 0, 0, 0, 1,
           beat_t'{32'h100, 4'hF, 32'h0, 1'b0}, NB, res_t'{32'h0BADF00D, 1'b0, 2'b00, 2, 1});
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/riscv_lsu_split.md
# riscv_lsu_split

Second-generation load/store unit between the core's memory stage and the data-memory bus. It adds a registered request state machine and parametrised address width. It performs misaligned halfword/word accesses as two aligned bus beats, and aborts stuck bus transactions with a timeout counter. Byte-enable generation, store-data replication/shifting and load sign/zero extension match the existing LSU contract.

## Interface
Parameters:
- ADDR_W, 32, width of core/mem address (>= 3).
- TIMEOUT, 255, max cycles a beat may wait for mem_ready_i; 0 disables the timeout.

Ports:
- clk_i  in  1  clock, all state updates on posedge.
- rst_i  in  1  reset, asynchronous, active-high.
- core_req_i  in  1  access request; held by core until core_stall_o low.
- core_we_i  in  1  1 = store.
- core_size_i  in  3  decoder_pkg encoding: LDST_B=0, LDST_H=1, LDST_W=2, LDST_BU=4, LDST_HU=5; others treated as W.
- core_addr_i  in  ADDR_W  byte address.
- core_wd_i  in  32  store data, LSB-aligned.
- core_rd_o  out  32  extended load data, valid when core_stall_o=0 and core_req_i=1.
- core_stall_o  out  1  stall core.
- core_fault_o  out  1  access faulted; valid with core_stall_o=0.
- core_fault_cause_o  out  2  01 misaligned, 10 bus timeout, 00 none.
- mem_req_o  out  1  bus beat request.
- mem_we_o  out  1  beat is write.
- mem_be_o  out  4  byte enables.
- mem_addr_o  out  ADDR_W  word-aligned beat address (addr[1:0]=0).
- mem_wd_o  out  32  beat write data.
- mem_rd_i  in  32  read data, valid with mem_ready_i.
- mem_ready_i  in  1  beat complete in this cycle.

## Operation
- States: IDLE, BEAT0, BEAT1, DONE.
- IDLE: on core_req_i, latch addr, size, we, wd; go to BEAT0. core_stall_o=1.
- off=addr[1:0]. Base mask: B/BU=0001, H/HU=0011, W=1111. be8 = base<<off (8 bits). sd64 = {32'b0, wd}<<(8*off).
- split = be8[7:4]!=0. Beat0 uses addr with bits[1:0] cleared, be8[3:0], sd64[31:0]. Beat1 uses beat0 addr+4 (wraps modulo 2^ADDR_W), be8[7:4], sd64[63:32].
- BEAT0: mem_req_o=1. On mem_ready_i: capture mem_rd_i to rd0. Go to BEAT1 if split, else DONE.
- BEAT1: mem_req_o=1. On mem_ready_i: capture rd1; go to DONE.
- DONE: core_stall_o=0; result = ({rd1, rd0}>>(8*off))[31:0], sign- or zero-extended per size. All result values are registered. Next state is IDLE.
- Stores return core_rd_o=0.
- Timeout: a counter clears on entry to each beat and increments while waiting. When it reaches TIMEOUT without mem_ready_i: drop mem_req_o, go to DONE with cause 10.
- A completed beat0 of a timed-out split store is not undone.
- mem_req_o, mem_we_o, mem_be_o, mem_addr_o and mem_wd_o are driven from registers only. mem_be_o and mem_wd_o are 0 outside BEAT0/BEAT1.
- core_req_i dropping mid-access does not abort; the access completes.

## Timing
- Reset (async): state IDLE. All outputs 0 except core_stall_o, which follows core_req_i in IDLE. Counter, rd0, rd1 and latched fields are cleared.
- Reset asserted mid-beat drops mem_req_o immediately. Any beat already acknowledged stays written.
- Aligned access, ready on first beat cycle: 3 cycles from core_req_i to retire (IDLE, BEAT0, DONE). Stall is high for 2 cycles.
- Split access, zero bus wait: 4 cycles. Each bus wait cycle adds 1.
- Back-to-back: a new core_req_i in the cycle after DONE is accepted in IDLE. There is no dead cycle beyond IDLE itself.
- mem_ready_i outside BEAT0/BEAT1 is ignored.
- Ready arriving in the same cycle the counter hits TIMEOUT: ready wins, and no fault is raised.

## Configuration
- LSU_MISALIGN_SPLIT_EN defined: behaviour as above.
- LSU_MISALIGN_SPLIT_EN undefined: split accesses issue no bus beat. The FSM goes IDLE -> DONE with core_fault_o=1 and cause 01; BEAT1 logic is removed.

## Test plan
- LW addr 0x100, mem_rd_i 0x8899AABB, ready immediate -> one beat, be 1111, core_rd_o 0x8899AABB, stall high 2 cycles.
- LB addr 0x103, mem_rd_i 0x80112233 -> be 1000, core_rd_o 0xFFFFFF80; LBU same -> 0x00000080.
- SW 0xDEADBEEF addr 0x201 (split enabled) -> beat0 addr 0x200 be 1110 wd 0xADBEEF00; beat1 addr 0x204 be 0001 wd 0x000000DE.
- LH addr 0x103, beat0 rd 0x34xxxxxx, beat1 rd 0xxxxxxx12 -> core_rd_o 0x00001234; LHU with 0x80 high byte -> 0x00008034.
- TIMEOUT=4, mem_ready_i held 0 -> mem_req_o drops after 4 wait cycles, core_fault_o=1, cause 10; ready on the 4th cycle -> no fault.
- Macro undefined, LW addr 0x002 -> mem_req_o never asserts, fault cause 01. Reset pulse during BEAT0 -> IDLE, mem_req_o 0 asynchronously.
